// File: rtl/maxnet_iter_ctrl.sv
// MaxNet iteration controller.
// Sequences one activation load followed by inhibition updates until at most
// one neuron is still nonzero or the iteration budget runs out, then reports
// the winner, the number of updates issued and whether the run timed out.
module maxnet_iter_ctrl #(
    parameter int NUM_NEURONS = 4,
    parameter int IDX_W       = 2,
    parameter int MAX_ITER    = 64,
    parameter int ITER_W      = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_NEURONS-1:0] nz_flags,
    output logic                   busy,
    output logic                   load_en,
    output logic                   update_en,
    output logic                   done,
    output logic                   winner_valid,
    output logic [IDX_W-1:0]       winner_idx,
    output logic [ITER_W-1:0]      iter_count,
    output logic                   timeout
);

    localparam int CNT_W = $clog2(NUM_NEURONS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_UPDATE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ITER_W-1:0]  r_iter;
    logic               r_winner_valid;
    logic [IDX_W-1:0]   r_winner_idx;
    logic               r_timeout;
    logic [CNT_W-1:0]   w_count;
    logic               w_at_limit;
    logic               w_accept;

    // Number of neurons whose activation is still nonzero.
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_NEURONS-1:0] f);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            c = c + CNT_W'(f[i]);
        end
        return c;
    endfunction

    // Index of the lowest set bit; only meaningful when exactly one bit is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_NEURONS-1:0] f);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (f[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign w_count    = popcount(nz_flags);
    assign w_at_limit = (r_iter == ITER_W'(MAX_ITER));
    assign w_accept   = (r_state == S_IDLE) && start;

    // State register; reset drops straight back to IDLE, even mid-run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and strobes, which are pure functions of the state.
    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        load_en   = 1'b0;
        update_en = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                load_en = 1'b1;
                w_next  = S_CHECK;
            end
            S_CHECK: begin
                if ((w_count <= CNT_W'(1)) || w_at_limit) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                update_en = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                w_next = S_CHECK;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Iteration counter and result registers; results hold until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iter         <= '0;
            r_winner_valid <= 1'b0;
            r_winner_idx   <= '0;
            r_timeout      <= 1'b0;
        end else if (w_accept) begin
            r_iter         <= '0;
            r_winner_valid <= 1'b0;
            r_winner_idx   <= '0;
            r_timeout      <= 1'b0;
        end else if (r_state == S_UPDATE) begin
            // Saturate rather than wrap; CHECK never lets us get here at the limit.
            if (!w_at_limit) begin
                r_iter <= r_iter + 1'b1;
            end
        end else if (r_state == S_CHECK) begin
            if (w_count == '0) begin
                r_winner_valid <= 1'b0;
                r_winner_idx   <= '0;
                r_timeout      <= 1'b0;
            end else if (w_count == CNT_W'(1)) begin
                r_winner_valid <= 1'b1;
                r_winner_idx   <= lowest_set(nz_flags);
                r_timeout      <= 1'b0;
            end else if (w_at_limit) begin
                r_winner_valid <= 1'b0;
                r_winner_idx   <= '0;
                r_timeout      <= 1'b1;
            end
        end
    end

    assign winner_valid = r_winner_valid;
    assign winner_idx   = r_winner_idx;
    assign iter_count   = r_iter;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_maxnet_iter_ctrl.sv
// Testbench for maxnet_iter_ctrl: directed and randomized runs compared
// cycle by cycle against a run-level model of the competition.
module tb_maxnet_iter_ctrl;

    localparam int NN   = 4;
    localparam int IW   = 2;
    localparam int MI   = 3;
    localparam int ITW  = 7;
    localparam int MAXC = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NN-1:0] nz_flags = '0;
    logic          busy, load_en, update_en, done, winner_valid, timeout;
    logic [IW-1:0] winner_idx;
    logic [ITW-1:0] iter_count;

    int tests = 0;
    int fails = 0;

    // Flag value driven during each cycle of a run, and start pokes per cycle.
    logic [NN-1:0] fl [0:MAXC];
    logic          sp [0:MAXC];

    maxnet_iter_ctrl #(
        .NUM_NEURONS(NN),
        .IDX_W      (IW),
        .MAX_ITER   (MI),
        .ITER_W     (ITW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .nz_flags    (nz_flags),
        .busy        (busy),
        .load_en     (load_en),
        .update_en   (update_en),
        .done        (done),
        .winner_valid(winner_valid),
        .winner_idx  (winner_idx),
        .iter_count  (iter_count),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Competition outcome from the flags seen at each CHECK (cycles 2, 5, 8, ...).
    task automatic model(output int n, output logic wv, output logic [IW-1:0] wi, output logic to);
        logic fin;
        logic [NN-1:0] f;
        int pc;
        fin = 1'b0;
        n = 0; wv = 1'b0; wi = '0; to = 1'b0;
        for (int j = 0; j <= MI; j++) begin
            if (!fin) begin
                f  = fl[2 + 3 * j];
                pc = $countones(f);
                if (pc <= 1) begin
                    fin = 1'b1;
                    n   = j;
                    wv  = (pc == 1);
                    for (int b = 0; b < NN; b++) begin
                        if (f[b]) wi = IW'(b);
                    end
                end else if (j == MI) begin
                    fin = 1'b1;
                    n   = j;
                    to  = 1'b1;
                end
            end
        end
    endtask

    task automatic fill_const(input logic [NN-1:0] v);
        for (int c = 0; c <= MAXC; c++) begin
            fl[c] = v;
            sp[c] = 1'b0;
        end
    endtask

    task automatic fill_random();
        for (int c = 0; c <= MAXC; c++) begin
            if ($urandom_range(0, 3) == 0) fl[c] = NN'(1) << $urandom_range(0, NN - 1);
            else                           fl[c] = NN'($urandom);
            sp[c] = 1'b0;
        end
    endtask

    // One full run: start pulse, then every cycle through two idle cycles after done.
    task automatic run(input string name, input logic poke, input logic rnd_poke);
        int n, dc, eit;
        logic ewv, eto;
        logic [IW-1:0] ewi;
        model(n, ewv, ewi, eto);
        dc = 3 + 3 * n;
        if (poke) begin
            sp[3]  = 1'b1;
            sp[dc] = 1'b1;
        end
        if (rnd_poke) begin
            for (int c = 2; c <= dc; c++) sp[c] = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= dc + 2; c++) begin
            nz_flags = fl[c];
            start    = sp[c] && (c >= 2) && (c <= dc);
            eit      = ((c - 1) / 3 < n) ? (c - 1) / 3 : n;
            chk($sformatf("%s c%0d load_en", name, c),   32'(load_en),   32'(c == 1));
            chk($sformatf("%s c%0d update_en", name, c), 32'(update_en), 32'((c >= 3) && (c < dc) && (c % 3 == 0)));
            chk($sformatf("%s c%0d done", name, c),      32'(done),      32'(c == dc));
            chk($sformatf("%s c%0d busy", name, c),      32'(busy),      32'(c <= dc));
            chk($sformatf("%s c%0d iter_count", name, c), 32'(iter_count), 32'(eit));
            chk($sformatf("%s c%0d winner_valid", name, c), 32'(winner_valid), 32'((c >= dc) ? ewv : 1'b0));
            chk($sformatf("%s c%0d winner_idx", name, c),   32'(winner_idx),   32'((c >= dc) ? ewi : '0));
            chk($sformatf("%s c%0d timeout", name, c),      32'(timeout),      32'((c >= dc) ? eto : 1'b0));
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 0);
        chk("rst load_en", 32'(load_en), 0);
        chk("rst done", 32'(done), 0);
        chk("rst iter_count", 32'(iter_count), 0);
        chk("rst winner_valid", 32'(winner_valid), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Immediate winner
        fill_const(4'b0100);
        run("winner", 1'b0, 1'b0);

        // Two iterations, then neuron 1 alone
        fill_const(4'b1111);
        for (int c = 6; c <= MAXC; c++) fl[c] = 4'b0010;
        run("two_iter", 1'b0, 1'b0);

        // All-zero flags
        fill_const(4'b0000);
        run("all_zero", 1'b0, 1'b0);

        // Timeout at MAX_ITER
        fill_const(4'b0011);
        run("timeout", 1'b0, 1'b0);

        // start pulsed during UPDATE and DONE is ignored; next run clears results
        fill_const(4'b1111);
        for (int c = 6; c <= MAXC; c++) fl[c] = 4'b0010;
        run("start_busy", 1'b1, 1'b0);
        fill_const(4'b0000);
        run("clear_after", 1'b0, 1'b0);

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            fill_random();
            run($sformatf("rnd%0d", r), 1'b0, 1'b1);
        end

        // Asynchronous reset mid-run
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        nz_flags = 4'b1111;
        repeat (4) @(posedge clk);
        #2;
        chk("pre-rst busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 0);
        chk("midrst load_en", 32'(load_en), 0);
        chk("midrst update_en", 32'(update_en), 0);
        chk("midrst done", 32'(done), 0);
        chk("midrst winner_valid", 32'(winner_valid), 0);
        chk("midrst winner_idx", 32'(winner_idx), 0);
        chk("midrst iter_count", 32'(iter_count), 0);
        chk("midrst timeout", 32'(timeout), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk($sformatf("postrst c%0d busy", c), 32'(busy), 0);
            chk($sformatf("postrst c%0d load_en", c), 32'(load_en), 0);
            chk($sformatf("postrst c%0d update_en", c), 32'(update_en), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/maxnet_iter_ctrl.md
Name: maxnet_iter_ctrl

Overview:
- Iteration controller for the MaxNet winner-take-all layer.
- Each neuron's 32-bit activation is OR-reduced to a nonzero flag. This block takes that flag vector and sequences the datapath: one load, then repeated inhibition updates.
- It stops when at most one neuron remains nonzero, or when the iteration budget is exhausted.
- It reports the winner index, the iteration count and the termination cause to the downstream classifier.

Parameters:
- NUM_NEURONS, 4, number of competing neurons; width of the nz_flags input; must be >= 2.
- IDX_W, 2, width of winner_idx; must satisfy 2**IDX_W >= NUM_NEURONS.
- MAX_ITER, 64, maximum number of update iterations before forced termination; must be >= 1.
- ITER_W, 7, width of iter_count; must hold MAX_ITER.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new competition; sampled only in IDLE.
- nz_flags  in  NUM_NEURONS  per-neuron nonzero flag from the OR-reducers; bit i = activation i != 0.
- busy  out  1  high in every state except IDLE.
- load_en  out  1  one-cycle strobe; datapath loads the initial activations.
- update_en  out  1  one-cycle strobe; datapath commits one inhibition iteration.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle on.
- winner_valid  out  1  exactly one neuron remained nonzero.
- winner_idx  out  IDX_W  index of the winning neuron.
- iter_count  out  ITER_W  number of update_en strobes issued in this run.
- timeout  out  1  run ended by MAX_ITER with two or more neurons still nonzero.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0; iteration counter 0. Takes effect immediately, including mid-run. No strobe is issued after reset releases until a new start.
- States: IDLE, LOAD, CHECK, UPDATE, WAIT, DONE. load_en is high exactly while in LOAD; update_en exactly while in UPDATE; done exactly while in DONE.
- IDLE: on start=1, go to LOAD.
  - Clear the iteration counter, winner_valid, timeout and winner_idx at this transition.
  - With start=0, stay in IDLE.
- LOAD -> CHECK unconditionally.
- CHECK: popcount nz_flags, then:
  - count == 0: winner_valid=0, winner_idx=0, timeout=0; go to DONE.
  - count == 1: winner_valid=1; winner_idx = index of the set bit; timeout=0; go to DONE.
  - count >= 2 and iteration counter == MAX_ITER: timeout=1, winner_valid=0, winner_idx=0; go to DONE.
  - otherwise: go to UPDATE.
- UPDATE: iteration counter += 1; go to WAIT. WAIT is a one-cycle settle for the datapath register and OR-reduce path; go to CHECK.
- DONE -> IDLE. winner_valid, winner_idx, iter_count and timeout hold until the next accepted start or reset.
- Latency: with start sampled at edge k, LOAD occupies cycle k+1 and CHECK cycle k+2. done is high in cycle k+3+3N, where N is the number of updates issued. iter_count = N.
- Counter saturation: the counter never exceeds MAX_ITER and never wraps.
- start while busy (including the DONE cycle): ignored, with no queuing.
- nz_flags is sampled only in CHECK; its value in other states has no effect.
- Multi-bit flags are handled by the popcount path. A priority-encode result is used only when count == 1.

Test Plan:
- Reset: assert rst_n=0 mid-run at any state -> busy, load_en, update_en, done, winner_valid, winner_idx, iter_count and timeout are all 0 immediately. After release, with no start, the block stays in IDLE.
- Immediate winner: start pulse with nz_flags=4'b0100 -> load_en in cycle k+1; no update_en; done in k+3; winner_valid=1, winner_idx=2, iter_count=0, timeout=0.
- Two iterations: nz_flags=4'b1111 at the first two CHECKs, then 4'b0010 -> exactly 2 update_en pulses, at k+3 and k+6; done at k+9; winner_idx=1, iter_count=2, winner_valid=1.
- All-zero: nz_flags=4'b0000 at the first CHECK -> done at k+3; winner_valid=0, winner_idx=0, timeout=0, iter_count=0.
- Timeout with MAX_ITER=3: nz_flags=4'b0011 held constant -> 3 update_en pulses; done at k+12; timeout=1, winner_valid=0, iter_count=3.
- start ignored while busy: pulse start during UPDATE and during DONE -> no extra load_en. Results from the run stay held. A later start in IDLE begins a fresh run and clears the previous results.
